// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and default widths for the DDS sweep controller.
package dds_sweep_ctrl_pkg;

    localparam int FREQ_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    // IDLE waits for start, ARM restarts the DDS phase, SWEEP steps the
    // frequency, LAST is the one-cycle decision point for repeat or finish.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SWEEP = 2'd2,
        LAST  = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_dwell_timer.sv
// Dwell timer: counts cycles spent at one frequency and flags the last one.
// The dwell length is captured once per sweep; a length of 0 behaves as 1.
module dds_dwell_timer
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] dwell,
    output logic             tc
);

    logic [CNT_W-1:0] dwell_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Capture the dwell length, lifting 0 to 1 so the terminal count always fires
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_reg <= CNT_W'(1);
        end else if (load) begin
            dwell_reg <= (dwell == '0) ? CNT_W'(1) : dwell;
        end
    end

    // Free-running count while enabled, wrapping to 0 on the terminal cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= tc ? '0 : cnt_reg + CNT_W'(1);
        end
    end

    assign tc = run && (cnt_reg == dwell_reg - CNT_W'(1));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer for the DDS phase accumulator.
// All outputs are registered; the sweep runs from shadow copies of the
// programming inputs so the register bank may change them at any time.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int FREQ_W = FREQ_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)
(
    input  logic              DAC_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [FREQ_W-1:0] f_start,
    input  logic [FREQ_W-1:0] f_step,
    input  logic [CNT_W-1:0]  num_steps,
    input  logic [CNT_W-1:0]  dwell,
    input  logic              repeat_en,
    output logic [FREQ_W-1:0] FreqCntrl,
    output logic              dds_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  step_idx
);

    sweep_state_t      state_reg;
    logic [FREQ_W-1:0] f_start_reg;
    logic [FREQ_W-1:0] f_step_reg;
    logic [CNT_W-1:0]  num_steps_reg;
    logic              repeat_reg;

    logic accept;
    logic kill;
    logic dwell_tc;

    // A start is honoured only from IDLE and only if abort is not also present
    assign accept = (state_reg == IDLE) && start && !abort;
    assign kill   = (state_reg != IDLE) && abort;

    dds_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk   (DAC_clk),
        .rst   (rst),
        .load  (accept),
        .clear ((state_reg == ARM) || kill),
        .run   (state_reg == SWEEP),
        .dwell (dwell),
        .tc    (dwell_tc)
    );

    // Sweep FSM with shadow registers and the modulo-2^FREQ_W frequency adder
    always_ff @(posedge DAC_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            f_start_reg   <= '0;
            f_step_reg    <= '0;
            num_steps_reg <= '0;
            repeat_reg    <= 1'b0;
            FreqCntrl     <= '0;
            dds_en        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            step_idx      <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                // Abort: stop the DDS, keep the last frequency word, no done
                state_reg <= IDLE;
                dds_en    <= 1'b0;
                busy      <= 1'b0;
                step_idx  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        dds_en   <= 1'b0;
                        busy     <= 1'b0;
                        step_idx <= '0;
                        if (accept) begin
                            f_start_reg   <= f_start;
                            f_step_reg    <= f_step;
                            num_steps_reg <= num_steps;
                            repeat_reg    <= repeat_en;
                            busy          <= 1'b1;
                            state_reg     <= ARM;
                        end
                    end
                    ARM: begin
                        // dds_en was low for this cycle, so the accumulator sits at phase 0
                        FreqCntrl <= f_start_reg;
                        dds_en    <= 1'b1;
                        step_idx  <= '0;
                        state_reg <= SWEEP;
                    end
                    SWEEP: begin
                        if (dwell_tc && (num_steps_reg != '0)) begin
                            if (step_idx == num_steps_reg - CNT_W'(1)) begin
                                state_reg <= LAST;
                            end else begin
                                FreqCntrl <= FreqCntrl + f_step_reg;
                                step_idx  <= step_idx + CNT_W'(1);
                            end
                        end
                    end
                    LAST: begin
                        if (repeat_reg) begin
                            // Restart the frequency ramp without touching the phase
                            FreqCntrl <= f_start_reg;
                            step_idx  <= '0;
                            state_reg <= SWEEP;
                        end else begin
                            dds_en    <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            step_idx  <= '0;
                            state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes the expected
// (cycle, frequency, step) of every enabled cycle and every done pulse;
// a monitor pops and compares whenever the DUT shows dds_en or done.
module tb_dds_sweep_ctrl;

    logic        DAC_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] num_steps;
    logic [15:0] dwell;
    logic        repeat_en;
    logic [31:0] FreqCntrl;
    logic        dds_en;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    typedef struct {
        int          cyc;
        logic [31:0] f;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dds_sweep_ctrl dut (
        .DAC_clk   (DAC_clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_step    (f_step),
        .num_steps (num_steps),
        .dwell     (dwell),
        .repeat_en (repeat_en),
        .FreqCntrl (FreqCntrl),
        .dds_en    (dds_en),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 DAC_clk = ~DAC_clk;

    always @(posedge DAC_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Reference model: the k-th step of a sweep sits at f_start + k*f_step
    // for dwell cycles (dwell 0 counts as 1); the final step is shown one
    // extra cycle while the sequencer decides repeat/finish. Enabled output
    // begins two cycles after the start cycle; done follows the last step.
    task automatic push_sweep(input logic [31:0] fs, input logic [31:0] fst,
                              input int n, input int d, input int periods,
                              input bit rep, input int c0, input int limit);
        int   dw;
        int   c;
        int   cnt;
        exp_t e;
        dw  = (d == 0) ? 1 : d;
        c   = c0 + 2;
        cnt = 0;
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < dw; j++) begin
                    if (limit >= 0 && cnt >= limit) return;
                    e.cyc = c; e.f = fs + 32'(k) * fst; e.idx = k;
                    exp_q.push_back(e);
                    c++; cnt++;
                end
            end
            if (limit >= 0 && cnt >= limit) return;
            e.cyc = c; e.f = fs + 32'(n - 1) * fst; e.idx = n - 1;
            exp_q.push_back(e);
            c++; cnt++;
        end
        if (!rep) done_q.push_back(c);
    endtask

    // Waits for the scoreboard to drain while scrambling the programming
    // inputs and issuing one stray start, both of which must be ignored.
    task automatic wait_drain(input int stray, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < budget) begin
            @(negedge DAC_clk);
            n++;
            start     = (cyc == stray);
            f_start   = $urandom;
            f_step    = $urandom;
            num_steps = 16'($urandom);
            dwell     = 16'($urandom);
            repeat_en = 1'($urandom);
        end
        start = 1'b0;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries and %0d done left after %0d cycles, required 0", exp_q.size(), done_q.size(), n);
        end
        @(negedge DAC_clk);
    endtask

    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fst, input int n, input int d);
        int c0;
        f_start = fs; f_step = fst; num_steps = 16'(n); dwell = 16'(d); repeat_en = 1'b0;
        start = 1'b1;
        c0 = cyc;
        $display("sweep start cyc %0d f_start %h f_step %h steps %0d dwell %0d", c0, fs, fst, n, d);
        push_sweep(fs, fst, n, d, 1, 1'b0, c0, -1);
        @(negedge DAC_clk);
        start = 1'b0;
        wait_drain(c0 + 3, 500);
    endtask

    task automatic wait_cyc(input int target);
        int g = 0;
        while (cyc != target && g < 1000) begin
            @(negedge DAC_clk);
            g++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL wait_cyc: at cycle %0d, required %0d", cyc, target);
        end
    endtask

    // Monitor: compare every enabled cycle and every done pulse
    initial begin
        exp_t e;
        int   dc;
        forever begin
            @(negedge DAC_clk);
            if (dds_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL en_unexpected: cyc %0d dds_en 1 FreqCntrl %h, required dds_en 0", cyc, FreqCntrl);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || FreqCntrl !== e.f || step_idx !== 16'(e.idx)) begin
                        errors++;
                        $display("FAIL en_cycle: cyc %0d FreqCntrl %h step_idx %0d, required cyc %0d FreqCntrl %h step_idx %0d",
                                 cyc, FreqCntrl, step_idx, e.cyc, e.f, e.idx);
                    end else begin
                        $display("ok   en cyc %0d FreqCntrl %h step_idx %0d", cyc, FreqCntrl, step_idx);
                    end
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done at cyc %0d, required no done", cyc);
                end else begin
                    dc = done_q.pop_front();
                    if (dc != cyc || busy !== 1'b0 || dds_en !== 1'b0) begin
                        errors++;
                        $display("FAIL done_cycle: done at cyc %0d busy %b dds_en %b, required cyc %0d busy 0 dds_en 0", cyc, busy, dds_en, dc);
                    end else begin
                        $display("ok   done cyc %0d", cyc);
                    end
                end
            end
        end
    end

    initial begin
        int c0;
        logic [31:0] fs;
        logic [31:0] fst;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        f_start = '0; f_step = '0; num_steps = '0; dwell = '0; repeat_en = 1'b0;
        repeat (3) @(negedge DAC_clk);
        chk("reset_freq", FreqCntrl, 32'h0);
        chk("reset_en", 32'(dds_en), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_step", 32'(step_idx), 32'h0);
        rst = 1'b0;
        @(negedge DAC_clk);

        // Basic up-sweep and down-sweep with wrap-around
        run_sweep(32'h0000_1000, 32'h0000_0100, 4, 3);
        run_sweep(32'h0000_0080, 32'hFFFF_FF00, 3, 1);

        // Continuous tone with dwell 0, then abort
        f_start = 32'h2000; f_step = 32'h55; num_steps = 16'd0; dwell = 16'd0; repeat_en = 1'b0;
        start = 1'b1;
        c0 = cyc;
        $display("tone start cyc %0d", c0);
        for (int i = 0; i < 100; i++) begin
            exp_t e;
            e.cyc = c0 + 2 + i; e.f = 32'h2000; e.idx = 0;
            exp_q.push_back(e);
        end
        @(negedge DAC_clk);
        start = 1'b0;
        wait_cyc(c0 + 101);
        abort = 1'b1;
        @(negedge DAC_clk);
        abort = 1'b0;
        chk("tone_abort_en", 32'(dds_en), 32'h0);
        chk("tone_abort_busy", 32'(busy), 32'h0);
        chk("tone_abort_freq", FreqCntrl, 32'h2000);
        chk("tone_queue_empty", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge DAC_clk);

        // Repeating sweep for three periods, ended by abort on the last cycle
        fs = $urandom; fst = $urandom;
        f_start = fs; f_step = fst; num_steps = 16'd2; dwell = 16'd2; repeat_en = 1'b1;
        start = 1'b1;
        c0 = cyc;
        $display("repeat start cyc %0d f_start %h f_step %h", c0, fs, fst);
        push_sweep(fs, fst, 2, 2, 3, 1'b1, c0, -1);
        @(negedge DAC_clk);
        start = 1'b0; f_step = ~fst; f_start = ~fs; repeat_en = 1'b0;
        wait_cyc(c0 + 16);
        abort = 1'b1;
        @(negedge DAC_clk);
        abort = 1'b0;
        chk("repeat_abort_en", 32'(dds_en), 32'h0);
        chk("repeat_abort_busy", 32'(busy), 32'h0);
        chk("repeat_abort_freq", FreqCntrl, fs + fst);
        chk("repeat_queue_empty", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge DAC_clk);

        // start together with abort must not launch a sweep
        f_start = 32'h1234; num_steps = 16'd2; dwell = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge DAC_clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_abort_busy", 32'(busy), 32'h0);
            @(negedge DAC_clk);
        end

        // Randomised one-shot sweeps
        for (int t = 0; t < 20; t++) begin
            run_sweep($urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, 4));
        end

        // Asynchronous reset at the start of step 2
        f_start = 32'h1000; f_step = 32'h100; num_steps = 16'd4; dwell = 16'd3; repeat_en = 1'b0;
        start = 1'b1;
        c0 = cyc;
        $display("reset-test start cyc %0d", c0);
        push_sweep(32'h1000, 32'h100, 4, 3, 1, 1'b0, c0, 7);
        @(negedge DAC_clk);
        start = 1'b0;
        wait_cyc(c0 + 8);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_freq", FreqCntrl, 32'h0);
        chk("async_rst_en", 32'(dds_en), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_step", 32'(step_idx), 32'h0);
        chk("async_rst_queue", 32'(exp_q.size()), 32'h0);
        repeat (2) @(negedge DAC_clk);
        #2 rst = 1'b0;
        @(negedge DAC_clk);
        run_sweep(32'hABCD_0000, 32'h0001_0001, 3, 2);

        chk("final_exp_queue", 32'(exp_q.size()), 32'h0);
        chk("final_done_queue", 32'(done_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencer for the DDS phase-accumulator datapath. Drives FreqCntrl and en from a programmed linear frequency sweep: start frequency, signed step, step count and dwell time per step.
- Sits between the AXI register bank and the DDS, in the DAC_clk domain.
- Supports one-shot sweeps, repeating sweeps, a continuous single tone, and abort.

Parameters:
- FREQ_W, 32, width of the frequency control word and the sweep arithmetic.
- CNT_W, 16, width of the step counter and the dwell counter.

Ports:
- DAC_clk  input  1  sole clock for the block.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep. Sampled only in IDLE.
- abort  input  1  single-cycle request to stop immediately. Takes effect in any state.
- f_start  input  FREQ_W  first frequency word of the sweep.
- f_step  input  FREQ_W  signed frequency increment applied per step.
- num_steps  input  CNT_W  number of steps; 0 means a continuous tone at f_start.
- dwell  input  CNT_W  DAC_clk cycles spent at each frequency; 0 is treated as 1.
- repeat_en  input  1  when 1, the sweep restarts from f_start after the last step.
- FreqCntrl  output  FREQ_W  frequency word to the DDS.
- dds_en  output  1  DDS enable. Low forces the DDS accumulator to 0.
- busy  output  1  high in ARM, SWEEP and LAST.
- done  output  1  one-cycle pulse when a non-repeating sweep completes.
- step_idx  output  CNT_W  index of the current step, starting at 0.

Behaviour:
- Reset (async, rst=1): state IDLE; FreqCntrl=0, dds_en=0, busy=0, done=0, step_idx=0, dwell counter=0. All outputs are registered.
- IDLE: outputs hold their reset values, except that FreqCntrl keeps its last value.
  - start=1 and abort=0: latch f_start, f_step, num_steps, max(dwell,1) and repeat_en into shadow registers, then go to ARM.
  - Inputs may change freely after the latch; the running sweep uses only the shadow copies.
- ARM, exactly 1 cycle:
  - FreqCntrl<=f_start, dds_en<=0 so the accumulator restarts at phase 0.
  - step_idx<=0, dwell counter<=0. Go to SWEEP.
- SWEEP:
  - dds_en=1. The dwell counter increments every cycle.
  - When dwell counter == dwell_s-1:
    - Counter goes back to 0.
    - If num_steps_s==0: stay in SWEEP with FreqCntrl unchanged (continuous tone).
    - Else if step_idx == num_steps_s-1: go to LAST.
    - Else: FreqCntrl<=FreqCntrl+f_step_s and step_idx<=step_idx+1.
- Timing: the first SWEEP cycle with dds_en=1 is cycle N+2 after start is sampled in IDLE at cycle N. Each frequency is presented for exactly dwell_s cycles.
- LAST, 1 cycle:
  - If repeat_en_s=1: FreqCntrl<=f_start, step_idx<=0, dds_en stays 1, go to SWEEP. There is no phase reset on repeat, so phase is continuous.
  - Otherwise: dds_en<=0, done<=1 for this cycle only, go to IDLE.
- Arithmetic: addition is modulo 2^FREQ_W. Wrap-around is intended; no saturation. A negative f_step gives a down-sweep.
- abort=1 in any non-IDLE state: next cycle state=IDLE, dds_en=0, busy=0, no done pulse, FreqCntrl holds its last value.
- abort and start in the same cycle: abort wins and the sweep does not start.
- start while busy: ignored.
- rst asserted mid-sweep: immediate return to the reset values; no done pulse.
- Total cycles from start to done (non-repeating, num_steps>=1): 2 + num_steps*dwell_s + 1.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE, ARM, SWEEP, LAST;
  - default FREQ_W and CNT_W.
- One sub-module is natural: dds_dwell_timer, a loadable counter with a terminal-count pulse and the dwell=0→1 clamp.
- The FSM, shadow registers and frequency adder stay in dds_sweep_ctrl.

Test Plan:
- Basic sweep: f_start=0x1000, f_step=0x100, num_steps=4, dwell=3, start pulse.
  - FreqCntrl = 0x1000, 0x1100, 0x1200, 0x1300, each for 3 cycles with dds_en=1.
  - done pulses once at cycle 15 after start. dds_en is low in the ARM cycle.
- Down-sweep wrap: f_start=0x00000080, f_step=0xFFFFFF00 (-256), num_steps=3, dwell=1.
  - FreqCntrl = 0x00000080, 0xFFFFFF80, 0xFFFFFE80.
- Continuous and dwell clamp: num_steps=0, dwell=0, f_start=0x2000.
  - FreqCntrl stays 0x2000 with dds_en=1 and no done for 100 cycles.
  - Abort → dds_en=0 and busy=0 on the next cycle, no done.
- Repeat: num_steps=2, dwell=2, repeat_en=1.
  - FreqCntrl pattern f_start, f_start+step repeats for 3 periods.
  - dds_en never drops after the first SWEEP cycle; done is never asserted.
- Races:
  - start and abort in the same cycle → stays IDLE.
  - start during SWEEP → ignored, step_idx sequence unchanged.
  - f_step changed mid-sweep → no effect on FreqCntrl.
- Async reset: assert rst at step 2, between clock edges.
  - Outputs go to zero without a clock edge.
  - After release, a new start runs a normal sweep from step 0.
